// File: rtl/jt12_ch_demux.sv
// jt12_ch_demux
//
// Receiving end of the six-channel time-multiplexed sample stream. A mod-6 slot
// counter is locked to the channel-0 frame sync; each slot's sample is captured
// into a per-channel buffer, and every complete frame is copied in one step into a
// published bank. Readers only ever see whole frames.
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset, released synchronously to clk
//   cen_i         clock enable; one slot per clk cycle with cen_i=1
//   sync_i        marks the channel-0 slot (sampled only with cen_i=1)
//   din_i         sample for the current slot (sampled only with cen_i=1)
//   rd_sel_i      channel to read, 0..5 (6 and 7 read as 0)
//   rd_data_o     registered published sample for rd_sel_i (1-clk latency)
//   slot_o        channel index of the most recently captured sample
//   locked_o      high while the stream is synchronised
//   frame_done_o  one-clk pulse when a new frame is published
//   sync_err_o    one-clk pulse on a sync violation (early or missing sync)

module jt12_ch_demux #(
    parameter int unsigned W = 14
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cen_i,
    input  logic         sync_i,
    input  logic [W-1:0] din_i,
    input  logic [2:0]   rd_sel_i,
    output logic [W-1:0] rd_data_o,
    output logic [2:0]   slot_o,
    output logic         locked_o,
    output logic         frame_done_o,
    output logic         sync_err_o
);

    localparam int unsigned NumCh = 6;

    typedef enum logic [0:0] {
        StUnlocked,
        StLocked
    } state_e;

    state_e         state_q;
    logic [2:0]     cnt_q;          // expected slot of the next cen cycle
    logic [2:0]     slot_q;
    logic           frame_done_q;
    logic           sync_err_q;
    logic [W-1:0]   rd_data_q;
    logic [W-1:0]   cap_q  [NumCh];
    logic [W-1:0]   bank_q [NumCh];

    // Counter values 6 and 7 cannot be reached; should one appear anyway it is
    // treated as slot 0 so the next sync brings the stream back into step.
    logic [2:0] cnt_eff;
    logic [2:0] cnt_inc;
    logic       rd_valid;

    always_comb begin
        cnt_eff  = (cnt_q > 3'd5) ? 3'd0 : cnt_q;
        cnt_inc  = (cnt_eff == 3'd5) ? 3'd0 : cnt_eff + 3'd1;
        rd_valid = (rd_sel_i < 3'd6);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StUnlocked;
            cnt_q        <= 3'd0;
            slot_q       <= 3'd0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
            rd_data_q    <= '0;
            for (int i = 0; i < NumCh; i++) begin
                cap_q[i]  <= '0;
                bank_q[i] <= '0;
            end
        end else begin
            // Pulses self-clear every clk, independent of cen_i.
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;

            // Read port runs every clk from the bank as it stood before this edge,
            // so a same-clk publish shows up one clk later.
            rd_data_q <= rd_valid ? bank_q[rd_sel_i] : '0;

            if (cen_i) begin
                unique case (state_q)
                    StUnlocked: begin
                        if (sync_i) begin
                            cap_q[0] <= din_i;
                            slot_q   <= 3'd0;
                            cnt_q    <= 3'd1;
                            state_q  <= StLocked;
                        end
                    end

                    StLocked: begin
                        if (sync_i) begin
                            // Normal frame start, or an early sync that abandons
                            // the partial frame; either way this slot is channel 0.
                            if (cnt_eff != 3'd0) begin
                                sync_err_q <= 1'b1;
                            end
                            cap_q[0] <= din_i;
                            slot_q   <= 3'd0;
                            cnt_q    <= 3'd1;
                        end else if (cnt_eff == 3'd0) begin
                            // Missing sync at the frame boundary: drop lock.
                            sync_err_q <= 1'b1;
                            cnt_q      <= 3'd0;
                            state_q    <= StUnlocked;
                        end else begin
                            cap_q[cnt_eff] <= din_i;
                            slot_q         <= cnt_eff;
                            cnt_q          <= cnt_inc;
                            if (cnt_eff == 3'd5) begin
                                // Slot-5 sample goes straight into the bank since
                                // its capture register is only written this edge.
                                for (int i = 0; i < NumCh - 1; i++) begin
                                    bank_q[i] <= cap_q[i];
                                end
                                bank_q[NumCh-1] <= din_i;
                                frame_done_q    <= 1'b1;
                            end
                        end
                    end

                    default: begin
                        state_q <= StUnlocked;
                    end
                endcase
            end
        end
    end

    assign rd_data_o    = rd_data_q;
    assign slot_o       = slot_q;
    assign locked_o     = (state_q == StLocked);
    assign frame_done_o = frame_done_q;
    assign sync_err_o   = sync_err_q;

endmodule

// File: tb/tb_jt12_ch_demux.sv
module tb_jt12_ch_demux;

    localparam int unsigned W = 14;

    logic         clk;
    logic         rst_n;
    logic         cen;
    logic         sync;
    logic [W-1:0] din;
    logic [2:0]   rd_sel;
    logic [W-1:0] rd_data;
    logic [2:0]   slot;
    logic         locked;
    logic         frame_done;
    logic         sync_err;

    int checks;
    int failures;

    jt12_ch_demux #(.W(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cen_i        (cen),
        .sync_i       (sync),
        .din_i        (din),
        .rd_sel_i     (rd_sel),
        .rd_data_o    (rd_data),
        .slot_o       (slot),
        .locked_o     (locked),
        .frame_done_o (frame_done),
        .sync_err_o   (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic         sync;
        logic [W-1:0] din;
        logic [2:0]   slot;
        logic         locked;
        logic         fd;
        logic         err;
    } vec_t;

    typedef struct packed {
        logic [2:0]   sel;
        logic [W-1:0] data;
    } rd_vec_t;

    vec_t    vecs [18];
    rd_vec_t rvecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cen slot followed by one idle clk (cen every 2nd clk). Outputs are
    // sampled just after the cen edge; the idle clk checks the pulses clear.
    task automatic slot_cycle(input logic s, input logic [W-1:0] d,
                              output logic [2:0] o_slot, output logic o_locked,
                              output logic o_fd, output logic o_err);
        cen  = 1'b1;
        sync = s;
        din  = d;
        tick();
        o_slot   = slot;
        o_locked = locked;
        o_fd     = frame_done;
        o_err    = sync_err;
        cen  = 1'b0;
        sync = 1'b0;
        din  = '0;
        tick();
        check("pulse_clear_fd", 32'(frame_done), 32'd0);
        check("pulse_clear_err", 32'(sync_err), 32'd0);
    endtask

    task automatic read_ch(input logic [2:0] sel, input logic [W-1:0] exp, input string name);
        rd_sel = sel;
        tick();
        check(name, 32'(rd_data), 32'(exp));
    endtask

    task automatic do_slot_chk(input logic s, input logic [W-1:0] d, input logic [2:0] e_slot,
                               input logic e_locked, input logic e_fd, input logic e_err);
        logic [2:0] a_slot;
        logic a_locked, a_fd, a_err;
        slot_cycle(s, d, a_slot, a_locked, a_fd, a_err);
        check("slot", 32'(a_slot), 32'(e_slot));
        check("locked", 32'(a_locked), 32'(e_locked));
        check("frame_done", 32'(a_fd), 32'(e_fd));
        check("sync_err", 32'(a_err), 32'(e_err));
    endtask

    initial begin
        logic pulse_seen;
        checks   = 0;
        failures = 0;

        // Three frames, din = 100*frame + ch; frame_done on every slot-5 cen.
        for (int f = 0; f < 3; f++) begin
            for (int ch = 0; ch < 6; ch++) begin
                vecs[f*6+ch] = '{sync: (ch == 0), din: W'(100*f + ch), slot: 3'(ch),
                                 locked: 1'b1, fd: (ch == 5), err: 1'b0};
            end
        end
        for (int i = 0; i < 8; i++) begin
            rvecs[i] = '{sel: 3'(i), data: (i < 6) ? W'(200 + i) : W'(0)};
        end

        rst_n  = 1'b0;
        cen    = 1'b0;
        sync   = 1'b0;
        din    = '0;
        rd_sel = 3'd0;
        repeat (3) tick();
        check("rst_slot", 32'(slot), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_fd", 32'(frame_done), 32'd0);
        check("rst_err", 32'(sync_err), 32'd0);
        check("rst_rd", 32'(rd_data), 32'd0);
        #3 rst_n = 1'b1;
        tick();

        // Preamble: no sync, nothing locks or publishes.
        for (int i = 0; i < 10; i++) begin
            do_slot_chk(1'b0, W'(14'h1FFF), 3'd0, 1'b0, 1'b0, 1'b0);
        end
        read_ch(3'd0, W'(0), "pre_bank0");
        read_ch(3'd5, W'(0), "pre_bank5");

        // Table-driven frames.
        for (int i = 0; i < 18; i++) begin
            do_slot_chk(vecs[i].sync, vecs[i].din, vecs[i].slot, vecs[i].locked,
                        vecs[i].fd, vecs[i].err);
        end

        // Read-back of frame 2 including invalid selects.
        for (int i = 0; i < 8; i++) begin
            read_ch(rvecs[i].sel, rvecs[i].data, "rd_frame2");
        end

        // Read latency: changing rd_sel is not visible before the next edge.
        rd_sel = 3'd4;
        tick();
        rd_sel = 3'd1;
        #2 check("rd_latency_old", 32'(rd_data), 32'd204);
        tick();
        check("rd_latency_new", 32'(rd_data), 32'd201);

        // Early sync at cnt=3.
        do_slot_chk(1'b1, W'(300), 3'd0, 1'b1, 1'b0, 1'b0);
        do_slot_chk(1'b0, W'(301), 3'd1, 1'b1, 1'b0, 1'b0);
        do_slot_chk(1'b0, W'(302), 3'd2, 1'b1, 1'b0, 1'b0);
        do_slot_chk(1'b1, W'(400), 3'd0, 1'b1, 1'b0, 1'b1);
        read_ch(3'd0, W'(200), "early_no_publish");
        for (int ch = 1; ch < 6; ch++) begin
            do_slot_chk(1'b0, W'(400 + ch), 3'(ch), 1'b1, (ch == 5), 1'b0);
        end
        for (int ch = 0; ch < 6; ch++) begin
            read_ch(3'(ch), W'(400 + ch), "early_refresh");
        end

        // Full frame 5xx, then missing sync at the boundary.
        for (int ch = 0; ch < 6; ch++) begin
            do_slot_chk((ch == 0), W'(500 + ch), 3'(ch), 1'b1, (ch == 5), 1'b0);
        end
        do_slot_chk(1'b0, W'(999), 3'd5, 1'b0, 1'b0, 1'b1);
        do_slot_chk(1'b0, W'(998), 3'd5, 1'b0, 1'b0, 1'b0);
        read_ch(3'd3, W'(503), "missing_bank_kept");
        do_slot_chk(1'b1, W'(600), 3'd0, 1'b1, 1'b0, 1'b0);
        do_slot_chk(1'b0, W'(601), 3'd1, 1'b1, 1'b0, 1'b0);
        do_slot_chk(1'b0, W'(602), 3'd2, 1'b1, 1'b0, 1'b0);

        // Hold cen=0 for 50 clks with junk on sync/din.
        pulse_seen = 1'b0;
        cen  = 1'b0;
        sync = 1'b1;
        din  = W'(14'h2AAA);
        for (int i = 0; i < 50; i++) begin
            tick();
            if (frame_done || sync_err) pulse_seen = 1'b1;
        end
        sync = 1'b0;
        check("hold_no_pulse", 32'(pulse_seen), 32'd0);
        check("hold_slot", 32'(slot), 32'd2);
        check("hold_locked", 32'(locked), 32'd1);
        read_ch(3'd0, W'(500), "hold_bank0");
        do_slot_chk(1'b0, W'(603), 3'd3, 1'b1, 1'b0, 1'b0);
        do_slot_chk(1'b0, W'(604), 3'd4, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset mid-frame at slot 4.
        rd_sel = 3'd2;
        tick();
        check("pre_rst_rd", 32'(rd_data), 32'd502);
        #2 rst_n = 1'b0;
        #1;
        check("arst_slot", 32'(slot), 32'd0);
        check("arst_locked", 32'(locked), 32'd0);
        check("arst_rd", 32'(rd_data), 32'd0);
        check("arst_fd", 32'(frame_done), 32'd0);
        check("arst_err", 32'(sync_err), 32'd0);
        tick();
        #2 rst_n = 1'b1;
        tick();
        do_slot_chk(1'b0, W'(605), 3'd0, 1'b0, 1'b0, 1'b0);
        read_ch(3'd2, W'(0), "arst_bank_cleared");
        do_slot_chk(1'b1, W'(700), 3'd0, 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
